spi_master_fifo: RTL

//  Parametrised SPI master; successor to the fixed 8-bit, mode-0, sys_clk/2 SPI core.

---
 rtl/spi_master_fifo.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_fifo.sv
// CPU-driven SPI master with runtime CPOL/CPHA/bit order, programmable SCLK divider
// and TX/RX FIFOs so that back-to-back words can be sent with slave select held.
module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SLAVES = 1,
    parameter int DIV_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic                  irq,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [DATA_W-1:0]     tx_mem_r [FIFO_DEPTH];
    logic [DATA_W-1:0]     rx_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
    logic [AW:0]           tx_cnt_r, rx_cnt_r;
    logic [8:0]            ctrl_r;
    logic [DIV_W-1:0]      div_r, div_l_r, hp_cnt_r;
    logic [NUM_SLAVES-1:0] sel_r;
    logic                  toe_r, roe_r;
    logic [1:0]            state_r;
    logic [EW-1:0]         edge_r;
    logic [DATA_W-1:0]     tx_sr_r, rx_sr_r, tx_next_s;
    logic                  cpol_l_r, cpha_l_r, lsb_l_r;

    logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic tx_push_s, tx_ovf_s, tx_pop_s, rx_done_s, rx_push_s, rx_ovf_s, rx_pop_s;
    logic hp_end_s, odd_s, sample_s, shift_s, last_s, status_wr_s;
    logic tmt_s, busy_s, unused_wdata_s;
    logic [EW-1:0] edge_k_s;
    logic [15:0]   status_s, rd_mux_s;

    function automatic logic pick_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic lsb,
                                                   input logic b);
        logic [DATA_W-1:0] bv;
        bv    = '0;
        bv[0] = b;
        return lsb ? ((v >> 1) | (bv << (DATA_W - 1))) : ((v << 1) | bv);
    endfunction

    assign tx_full_s   = (tx_cnt_r == DEPTH_C);
    assign tx_empty_s  = (tx_cnt_r == '0);
    assign rx_full_s   = (rx_cnt_r == DEPTH_C);
    assign rx_empty_s  = (rx_cnt_r == '0);
    assign tx_push_s   = wr_en & (addr == 3'd1) & ~tx_full_s;
    assign tx_ovf_s    = wr_en & (addr == 3'd1) & tx_full_s;
    assign status_wr_s = wr_en & (addr == 3'd2);
    assign hp_end_s    = (hp_cnt_r == div_l_r);
    assign tx_pop_s    = ~tx_empty_s & ((state_r == S_IDLE) | ((state_r == S_TRAIL) & hp_end_s));
    assign rx_done_s   = (state_r == S_TRAIL) & hp_end_s;
    assign rx_push_s   = rx_done_s & ~rx_full_s;
    assign rx_ovf_s    = rx_done_s & rx_full_s;
    assign rx_pop_s    = rd_en & (addr == 3'd0) & ~rx_empty_s;

    // Edge k is 1-based; with CPHA=1 the first bit is already on mosi, so edge 1 does not shift.
    assign edge_k_s  = edge_r + EW'(1);
    assign odd_s     = edge_k_s[0];
    assign sample_s  = cpha_l_r ? ~odd_s : odd_s;
    assign shift_s   = cpha_l_r ? (odd_s & (edge_k_s != EW'(1))) : ~odd_s;
    assign last_s    = (edge_k_s == LAST_EDGE);
    assign tx_next_s = shift_tx(tx_sr_r, lsb_l_r);

    assign busy_s         = (state_r != S_IDLE);
    assign tmt_s          = ~busy_s & tx_empty_s;
    assign status_s       = {10'b0, busy_s, roe_r, toe_r, ~rx_empty_s, ~tx_full_s, tmt_s};
    assign unused_wdata_s = ^wdata;

    // Register read multiplexer
    always_comb begin
        rd_mux_s = 16'h0000;
        case (addr)
            3'd0: begin
                if (!rx_empty_s) rd_mux_s = 16'(rx_mem_r[rx_rp_r]);
                else             rd_mux_s = 16'h0000;
            end
            3'd2:    rd_mux_s = status_s;
            3'd3:    rd_mux_s = {7'b0, ctrl_r};
            3'd4:    rd_mux_s = 16'(div_r);
            3'd5:    rd_mux_s = 16'(sel_r);
            default: rd_mux_s = 16'h0000;
        endcase
    end

    // FIFO storage arrays
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wp_r] <= wdata[DATA_W-1:0];
        if (rx_push_s) rx_mem_r[rx_wp_r] <= rx_sr_r;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp_r  <= '0;
            tx_rp_r  <= '0;
            tx_cnt_r <= '0;
            rx_wp_r  <= '0;
            rx_rp_r  <= '0;
            rx_cnt_r <= '0;
        end else begin
            if (tx_push_s) tx_wp_r <= tx_wp_r + AW'(1);
            if (tx_pop_s)  tx_rp_r <= tx_rp_r + AW'(1);
            if (rx_push_s) rx_wp_r <= rx_wp_r + AW'(1);
            if (rx_pop_s)  rx_rp_r <= rx_rp_r + AW'(1);
            tx_cnt_r <= tx_cnt_r + (AW + 1)'(tx_push_s) - (AW + 1)'(tx_pop_s);
            rx_cnt_r <= rx_cnt_r + (AW + 1)'(rx_push_s) - (AW + 1)'(rx_pop_s);
        end
    end

    // Bus registers, sticky overflow flags, read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r <= 9'h000;
            div_r  <= '0;
            sel_r  <= NUM_SLAVES'(1);
            toe_r  <= 1'b0;
            roe_r  <= 1'b0;
            rdata  <= 16'h0000;
            irq    <= 1'b0;
        end else begin
            if (wr_en && addr == 3'd3) ctrl_r <= wdata[8:0];
            if (wr_en && addr == 3'd4) div_r  <= wdata[DIV_W-1:0];
            if (wr_en && addr == 3'd5) sel_r  <= wdata[NUM_SLAVES-1:0];
            // A new overflow outranks a clearing write in the same cycle
            toe_r <= tx_ovf_s | (toe_r & ~status_wr_s);
            roe_r <= rx_ovf_s | (roe_r & ~status_wr_s);
            if (rd_en) rdata <= rd_mux_s;
            irq <= (~tx_full_s & ctrl_r[4]) | (~rx_empty_s & ctrl_r[5]) | (toe_r & ctrl_r[6])
                 | (roe_r & ctrl_r[7]) | (tmt_s & ctrl_r[8]);
        end
    end

    // Transfer FSM, shift registers and SPI pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            hp_cnt_r <= '0;
            edge_r   <= '0;
            tx_sr_r  <= '0;
            rx_sr_r  <= '0;
            div_l_r  <= '0;
            cpol_l_r <= 1'b0;
            cpha_l_r <= 1'b0;
            lsb_l_r  <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sclk <= ctrl_r[0];
                    ss_n <= ~(sel_r & {NUM_SLAVES{ctrl_r[3]}});
                end
                S_LEAD: begin
                    if (hp_end_s) begin
                        hp_cnt_r <= '0;
                        edge_r   <= '0;
                        state_r  <= S_SHIFT;
                    end else begin
                        hp_cnt_r <= hp_cnt_r + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (hp_end_s) begin
                        hp_cnt_r <= '0;
                        edge_r   <= edge_k_s;
                        sclk     <= ~sclk;
                        if (sample_s) rx_sr_r <= shift_rx(rx_sr_r, lsb_l_r, miso);
                        if (shift_s) begin
                            tx_sr_r <= tx_next_s;
                            mosi    <= pick_bit(tx_next_s, lsb_l_r);
                        end
                        if (last_s) state_r <= S_TRAIL;
                    end else begin
                        hp_cnt_r <= hp_cnt_r + DIV_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (hp_end_s) begin
                        hp_cnt_r <= '0;
                        state_r  <= S_IDLE;
                        sclk     <= ctrl_r[0];
                        ss_n     <= ~(sel_r & {NUM_SLAVES{ctrl_r[3]}});
                    end else begin
                        hp_cnt_r <= hp_cnt_r + DIV_W'(1);
                    end
                end
                default: state_r <= S_IDLE;
            endcase
            // Word load overrides the branch above; configuration is frozen for the whole word
            if (tx_pop_s) begin
                state_r  <= S_LEAD;
                hp_cnt_r <= '0;
                tx_sr_r  <= tx_mem_r[tx_rp_r];
                rx_sr_r  <= '0;
                mosi     <= pick_bit(tx_mem_r[tx_rp_r], ctrl_r[2]);
                cpol_l_r <= ctrl_r[0];
                cpha_l_r <= ctrl_r[1];
                lsb_l_r  <= ctrl_r[2];
                div_l_r  <= div_r;
                sclk     <= ctrl_r[0];
                ss_n     <= ~sel_r;
            end
        end
    end
endmodule
